// File: rtl/mag_stream_filter_if.sv
// Handshake bundle between the magnitude stage, the filter and its consumer.
// The master modport is the environment side; the slave modport is the filter.
interface mag_stream_filter_if;
   logic       in_valid;
   logic [7:0] in_mag;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_avg;
   logic [7:0] out_peak;
   logic       out_alarm;
   logic       out_warm;

   modport master (
      output in_valid, in_mag, out_ready,
      input  in_ready, out_valid, out_avg, out_peak, out_alarm, out_warm
   );

   modport slave (
      input  in_valid, in_mag, out_ready,
      output in_ready, out_valid, out_avg, out_peak, out_alarm, out_warm
   );
endinterface

// File: rtl/mag_stream_filter.sv
// Four-sample moving average / peak filter on a magnitude stream, with a
// hysteretic threshold alarm on the average and a one-deep output register.
module mag_stream_filter #(
   parameter int unsigned ALARM_HYST = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               clear,
   input  logic [7:0]         cfg_thresh,
   mag_stream_filter_if.slave s
);
   typedef enum logic {QUIET, ALARM} alarm_state_t;

   localparam logic [8:0] HYST9 = 9'(ALARM_HYST);

   alarm_state_t state_reg, state_next;

   logic [7:0] window_reg [4];
   logic [7:0] shift_in   [4];
   logic [9:0] sum_reg, sum_next;
   logic [2:0] count_reg, count_next;
   logic [7:0] avg_next, peak_next;
   logic [8:0] release_level;

   logic       out_valid_reg;
   logic [7:0] out_avg_reg, out_peak_reg;
   logic       out_alarm_reg, out_warm_reg;

   logic       in_ready, accept, drain;

   assign in_ready = rst_n & ena & ~clear & (~out_valid_reg | s.out_ready);
   assign accept   = s.in_valid & in_ready;
   assign drain    = ena & ~clear & out_valid_reg & s.out_ready;

   // shift_in[k] is what window slot k holds after an accept
   assign shift_in[0] = s.in_mag;
   genvar gi;
   generate
      for (gi = 1; gi < 4; gi++) begin : g_tap
         assign shift_in[gi] = window_reg[gi-1];
      end
   endgenerate

   // sum always contains window_reg[3], so the subtraction cannot wrap
   assign sum_next   = sum_reg + {2'b00, s.in_mag} - {2'b00, window_reg[3]};
   assign avg_next   = sum_next[9:2];
   assign count_next = (count_reg == 3'd4) ? count_reg : count_reg + 3'd1;

   always_comb begin
      peak_next = shift_in[0];
      for (int i = 1; i < 4; i++) begin
         if (shift_in[i] > peak_next) peak_next = shift_in[i];
      end
   end

   assign release_level = ({1'b0, cfg_thresh} > HYST9) ? ({1'b0, cfg_thresh} - HYST9) : 9'd0;

   always_comb begin
      state_next = state_reg;
      if (accept) begin
         case (state_reg)
            QUIET: if (avg_next > cfg_thresh) state_next = ALARM;
            ALARM: if ({1'b0, avg_next} < release_level) state_next = QUIET;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) state_reg <= QUIET;
      else                 state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         for (int i = 0; i < 4; i++) window_reg[i] <= '0;
         sum_reg       <= '0;
         count_reg     <= '0;
         out_valid_reg <= 1'b0;
         out_avg_reg   <= '0;
         out_peak_reg  <= '0;
         out_alarm_reg <= 1'b0;
         out_warm_reg  <= 1'b0;
      end else if (accept) begin
         for (int i = 0; i < 4; i++) window_reg[i] <= shift_in[i];
         sum_reg       <= sum_next;
         count_reg     <= count_next;
         out_valid_reg <= 1'b1;
         out_avg_reg   <= avg_next;
         out_peak_reg  <= peak_next;
         out_alarm_reg <= (state_next == ALARM);
         out_warm_reg  <= (count_next == 3'd4);
      end else if (drain) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign s.in_ready  = in_ready;
   assign s.out_valid = out_valid_reg;
   assign s.out_avg   = out_avg_reg;
   assign s.out_peak  = out_peak_reg;
   assign s.out_alarm = out_alarm_reg;
   assign s.out_warm  = out_warm_reg;
endmodule

// File: tb/tb_mag_stream_filter.sv
// Self-checking bench: directed vector table, corner sequences and random
// traffic compared against a sample-history reference model.
module tb_mag_stream_filter;
   localparam int HYST = 4;

   logic       clk = 1'b0;
   logic       rst_n, ena, clear;
   logic [7:0] cfg_thresh;

   always #5 clk = ~clk;

   mag_stream_filter_if bus();

   mag_stream_filter #(.ALARM_HYST(HYST)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .clear      (clear),
      .cfg_thresh (cfg_thresh),
      .s          (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state: newest sample at index 0
   int hist[$];
   bit m_alarm, m_ov, m_warm;
   int m_avg, m_peak;

   typedef struct {
      bit r, e, c, iv;
      int m, th;
      bit orr;
      bit x_ir, x_ov;
      int x_avg, x_peak;
      bit x_al, x_warm;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_edge(bit r, bit e, bit c, bit iv, int m, int th, bit orr);
      bit ir;
      int sum, pk, rel;
      ir = r && e && !c && (!m_ov || orr);
      if (!r || c) begin
         hist.delete();
         m_alarm = 0; m_ov = 0; m_avg = 0; m_peak = 0; m_warm = 0;
      end else if (iv && ir) begin
         hist.push_front(m);
         if (hist.size() > 4) void'(hist.pop_back());
         sum = 0; pk = 0;
         foreach (hist[k]) begin
            sum += hist[k];
            if (hist[k] > pk) pk = hist[k];
         end
         m_avg  = sum / 4;
         m_peak = pk;
         m_warm = (hist.size() == 4);
         rel = th - HYST;
         if (rel < 0) rel = 0;
         if (!m_alarm && m_avg > th)     m_alarm = 1;
         else if (m_alarm && m_avg < rel) m_alarm = 0;
         m_ov = 1;
      end else if (e && m_ov && orr) begin
         m_ov = 0;
      end
   endfunction

   // One clock: drive, check in_ready before the edge, check outputs after it.
   task automatic step(input bit r, input bit e, input bit c, input bit iv,
                       input int m, input int th, input bit orr, output bit ir_seen);
      bit exp_ir;
      rst_n = r; ena = e; clear = c;
      bus.in_valid = iv; bus.in_mag = 8'(m); cfg_thresh = 8'(th); bus.out_ready = orr;
      #1;
      exp_ir  = r && e && !c && (!m_ov || orr);
      ir_seen = bus.in_ready;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
      @(posedge clk);
      model_edge(r, e, c, iv, m, th, orr);
      #1;
      chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("out_avg",   32'(bus.out_avg),   32'(m_avg));
      chk("out_peak",  32'(bus.out_peak),  32'(m_peak));
      chk("out_alarm", 32'(bus.out_alarm), 32'(m_alarm));
      chk("out_warm",  32'(bus.out_warm),  32'(m_warm));
      if (iv && exp_ir)
         $display("accept mag=%0d thr=%0d -> avg=%0d peak=%0d alarm=%0d warm=%0d",
                  m, th, bus.out_avg, bus.out_peak, bus.out_alarm, bus.out_warm);
   endtask

   initial begin
      bit ir;
      int n_acc;
      logic [7:0] held_avg, held_peak;

      rst_n = 1'b0; ena = 1'b0; clear = 1'b0; cfg_thresh = '0;
      bus.in_valid = 1'b0; bus.in_mag = '0; bus.out_ready = 1'b0;

      //           r  e  c  iv mag th   or  ir ov avg pk  al w
      tbl[0]  = '{0, 1, 0, 1,  5, 255, 1,  0, 0,  0,  0, 0, 0};
      tbl[1]  = '{1, 1, 0, 1, 10, 255, 1,  1, 1,  2, 10, 0, 0};
      tbl[2]  = '{1, 1, 0, 1, 20, 255, 1,  1, 1,  7, 20, 0, 0};
      tbl[3]  = '{1, 1, 0, 1, 30, 255, 1,  1, 1, 15, 30, 0, 0};
      tbl[4]  = '{1, 1, 0, 1, 40, 255, 1,  1, 1, 25, 40, 0, 1};
      tbl[5]  = '{1, 1, 0, 1, 40,  30, 1,  1, 1, 32, 40, 1, 1};
      tbl[6]  = '{1, 1, 0, 1, 40,  30, 1,  1, 1, 37, 40, 1, 1};
      tbl[7]  = '{1, 1, 0, 1, 40,  30, 1,  1, 1, 40, 40, 1, 1};
      tbl[8]  = '{1, 1, 0, 1, 40,  30, 1,  1, 1, 40, 40, 1, 1};
      tbl[9]  = '{1, 1, 0, 1, 26,  30, 1,  1, 1, 36, 40, 1, 1};
      tbl[10] = '{1, 1, 0, 1, 26,  30, 1,  1, 1, 33, 40, 1, 1};
      tbl[11] = '{1, 1, 0, 1, 26,  30, 1,  1, 1, 29, 40, 1, 1};
      tbl[12] = '{1, 1, 0, 1, 26,  30, 1,  1, 1, 26, 26, 1, 1};
      tbl[13] = '{1, 1, 0, 1, 24,  30, 1,  1, 1, 25, 26, 0, 1};
      tbl[14] = '{1, 1, 0, 0, 99,  30, 1,  1, 0, 25, 26, 0, 1};
      tbl[15] = '{1, 1, 1, 1, 99,  30, 1,  0, 0,  0,  0, 0, 0};
      tbl[16] = '{1, 0, 0, 1, 50,  30, 1,  0, 0,  0,  0, 0, 0};

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].iv, tbl[i].m, tbl[i].th, tbl[i].orr, ir);
         chk($sformatf("vec%0d_ir",    i), 32'(ir),              32'(tbl[i].x_ir));
         chk($sformatf("vec%0d_ov",    i), 32'(bus.out_valid),   32'(tbl[i].x_ov));
         chk($sformatf("vec%0d_avg",   i), 32'(bus.out_avg),     32'(tbl[i].x_avg));
         chk($sformatf("vec%0d_peak",  i), 32'(bus.out_peak),    32'(tbl[i].x_peak));
         chk($sformatf("vec%0d_alarm", i), 32'(bus.out_alarm),   32'(tbl[i].x_al));
         chk($sformatf("vec%0d_warm",  i), 32'(bus.out_warm),    32'(tbl[i].x_warm));
      end

      // backpressure: one result held for 5 cycles while upstream keeps offering
      step(1, 1, 0, 1, 77, 200, 0, ir);
      held_avg = 8'd19; held_peak = 8'd77;
      for (int k = 0; k < 5; k++) begin
         step(1, 1, 0, 1, 88, 200, 0, ir);
         chk("bp_in_ready", 32'(ir), 32'd0);
         chk("bp_avg_stable", 32'(bus.out_avg), 32'(held_avg));
         chk("bp_peak_stable", 32'(bus.out_peak), 32'(held_peak));
      end
      step(1, 1, 0, 1, 88, 200, 1, ir);
      chk("bp_release_accept", 32'(ir), 32'd1);
      chk("bp_release_avg", 32'(bus.out_avg), 32'd41);

      // full throughput: accept and drain on every edge
      n_acc = 0;
      for (int k = 0; k < 8; k++) begin
         step(1, 1, 0, 1, 100 + 7 * k, 200, 1, ir);
         if (ir) n_acc++;
         chk("thru_valid", 32'(bus.out_valid), 32'd1);
      end
      chk("thru_accepts", 32'(n_acc), 32'd8);

      // clear with a held result and a pending sample
      step(1, 1, 0, 1, 250, 10, 0, ir);
      step(1, 1, 1, 1, 55, 10, 0, ir);
      chk("clr_valid", 32'(bus.out_valid), 32'd0);
      chk("clr_warm",  32'(bus.out_warm),  32'd0);
      chk("clr_alarm", 32'(bus.out_alarm), 32'd0);

      // ena low freezes a held result
      step(1, 1, 0, 1, 60, 10, 0, ir);
      for (int k = 0; k < 3; k++) begin
         step(1, 0, 0, 1, 200, 10, 1, ir);
         chk("ena_in_ready", 32'(ir), 32'd0);
         chk("ena_valid", 32'(bus.out_valid), 32'd1);
         chk("ena_avg", 32'(bus.out_avg), 32'd15);
      end

      // reset mid-stream discards the held result; next sample is the first
      step(0, 1, 0, 1, 60, 10, 0, ir);
      step(1, 1, 0, 1, 80, 255, 1, ir);
      chk("rst_first_avg",  32'(bus.out_avg),  32'd20);
      chk("rst_first_peak", 32'(bus.out_peak), 32'd80);
      chk("rst_first_warm", 32'(bus.out_warm), 32'd0);

      // threshold below hysteresis: alarm latches until clear
      step(1, 1, 1, 0, 0, 2, 1, ir);
      step(1, 1, 0, 1, 20, 2, 1, ir);
      for (int k = 0; k < 5; k++) step(1, 1, 0, 1, 0, 2, 1, ir);
      chk("latch_alarm", 32'(bus.out_alarm), 32'd1);

      // random traffic
      for (int k = 0; k < 600; k++) begin
         int th;
         th = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : $urandom_range(40, 200);
         step($urandom_range(0, 99) != 0, $urandom_range(0, 7) != 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 255), th, $urandom_range(0, 2) != 0, ir);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
